// File: rtl/lstm_gate_if.sv
// Handshake and data bundle for one lstm_gate_seq instance.
// The ovf signal exists only when LSTM_GATE_OVF_EN is defined.
interface lstm_gate_if #(
    parameter int dataWidth  = 8,
    parameter int inputSize  = 2,
    parameter int hiddenSize = 2
);
    logic                                      start;
    logic [dataWidth*inputSize-1:0]            x;
    logic [dataWidth*hiddenSize-1:0]           hid;
    logic [dataWidth*inputSize*hiddenSize-1:0] InW;
    logic [dataWidth*hiddenSize*hiddenSize-1:0] ReW;
    logic [dataWidth*hiddenSize-1:0]           b;
    logic                                      busy;
    logic                                      out_valid;
    logic [dataWidth*hiddenSize-1:0]           y;
`ifdef LSTM_GATE_OVF_EN
    logic                                      ovf;

    modport master (output start, x, hid, InW, ReW, b, input busy, out_valid, y, ovf);
    modport slave  (input start, x, hid, InW, ReW, b, output busy, out_valid, y, ovf);
`else
    modport master (output start, x, hid, InW, ReW, b, input busy, out_valid, y);
    modport slave  (input start, x, hid, InW, ReW, b, output busy, out_valid, y);
`endif
endinterface

// File: rtl/lstm_gate_seq.sv
// Sequential LSTM gate: one time-multiplexed MAC, hard sigmoid or hard tanh activation.
// Optional sticky clamp flag ovf is enabled by defining LSTM_GATE_OVF_EN.
//
// state | meaning
// IDLE  | waiting for start; operands latched on acceptance
// MAC   | one product term accumulated per cycle
// ACT   | activation of the finished sum written to y[n]
// DONE  | out_valid pulse, then back to IDLE
module lstm_gate_seq #(
    parameter int    dataWidth  = 8,
    parameter int    fracWidth  = 4,
    parameter int    inputSize  = 2,
    parameter int    hiddenSize = 2,
    parameter string actType    = "sigmoid"
) (
    input logic        clk,
    input logic        rst,
    lstm_gate_if.slave bus
);
    localparam int N    = inputSize + hiddenSize;
    localparam int accW = 2*dataWidth + $clog2(N+1);
    localparam int nW   = (hiddenSize > 1) ? $clog2(hiddenSize) : 1;
    localparam int tW   = (N > 1) ? $clog2(N) : 1;
    localparam bit is_tanh = (actType == "tanh");

    localparam logic signed [accW-1:0] one_val  = accW'(1 << fracWidth);
    localparam logic signed [accW-1:0] half_val = accW'(1 << (fracWidth-1));
    localparam logic signed [accW-1:0] neg_one  = -one_val;
    localparam logic signed [accW-1:0] zero_val = '0;

    typedef enum logic [1:0] {IDLE, MAC, ACT, DONE} state_t;

    state_t                                     state;
    logic [nW-1:0]                              n;
    logic [tW-1:0]                              t;
    logic signed [accW-1:0]                     acc;
    logic [dataWidth*inputSize-1:0]             x_q;
    logic [dataWidth*hiddenSize-1:0]            hid_q;
    logic [dataWidth*inputSize*hiddenSize-1:0]  inw_q;
    logic [dataWidth*hiddenSize*hiddenSize-1:0] rew_q;
    logic [dataWidth*hiddenSize-1:0]            b_q;

    int                              ni, ti, nb_idx;
    logic signed [dataWidth-1:0]     op_a, op_w;
    logic signed [2*dataWidth-1:0]   prod;
    logic signed [accW-1:0]          prod_ext, a_val, r_val;
    logic                            clamp;
    logic                            unused_bits;

    function automatic logic signed [accW-1:0] bias_ext(input logic signed [dataWidth-1:0] v);
        logic signed [accW-1:0] e;
        e = {{(accW-dataWidth){v[dataWidth-1]}}, v};
        return e <<< fracWidth;
    endfunction

    always_comb begin
        ni     = int'(n);
        ti     = int'(t);
        nb_idx = (ni + 1 < hiddenSize) ? ni + 1 : 0;
        op_a   = '0;
        op_w   = '0;
        if (ti < inputSize) begin
            op_a = x_q[dataWidth*ti +: dataWidth];
            op_w = inw_q[dataWidth*(inputSize*ni + ti) +: dataWidth];
        end else begin
            op_a = hid_q[dataWidth*(ti-inputSize) +: dataWidth];
            op_w = rew_q[dataWidth*(hiddenSize*ni + ti - inputSize) +: dataWidth];
        end
        prod     = op_a * op_w;
        prod_ext = {{(accW-2*dataWidth){prod[2*dataWidth-1]}}, prod};
    end

    // The clamp flag marks a saturated result; landing exactly on a bound is not a clamp.
    always_comb begin
        a_val = acc >>> fracWidth;
        clamp = 1'b0;
        if (is_tanh) begin
            r_val = a_val;
            if (a_val > one_val) begin
                r_val = one_val;
                clamp = 1'b1;
            end else if (a_val < neg_one) begin
                r_val = neg_one;
                clamp = 1'b1;
            end
        end else begin
            r_val = (a_val >>> 2) + half_val;
            if (r_val > one_val) begin
                r_val = one_val;
                clamp = 1'b1;
            end else if (r_val < zero_val) begin
                r_val = zero_val;
                clamp = 1'b1;
            end
        end
    end

    assign unused_bits = ^r_val[accW-1:dataWidth];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            n             <= '0;
            t             <= '0;
            acc           <= '0;
            x_q           <= '0;
            hid_q         <= '0;
            inw_q         <= '0;
            rew_q         <= '0;
            b_q           <= '0;
            bus.busy      <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.y         <= '0;
`ifdef LSTM_GATE_OVF_EN
            bus.ovf       <= 1'b0;
`endif
        end else begin
            bus.out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        x_q      <= bus.x;
                        hid_q    <= bus.hid;
                        inw_q    <= bus.InW;
                        rew_q    <= bus.ReW;
                        b_q      <= bus.b;
                        n        <= '0;
                        t        <= '0;
                        acc      <= bias_ext(bus.b[dataWidth-1:0]);
                        bus.busy <= 1'b1;
                        state    <= MAC;
`ifdef LSTM_GATE_OVF_EN
                        bus.ovf  <= 1'b0;
`endif
                    end
                end
                MAC: begin
                    acc <= acc + prod_ext;
                    if (ti == N-1) state <= ACT;
                    else           t     <= t + 1'b1;
                end
                ACT: begin
                    bus.y[dataWidth*ni +: dataWidth] <= r_val[dataWidth-1:0];
`ifdef LSTM_GATE_OVF_EN
                    if (clamp) bus.ovf <= 1'b1;
`endif
                    if (ni == hiddenSize-1) begin
                        state         <= DONE;
                        bus.out_valid <= 1'b1;
                    end else begin
                        n     <= n + 1'b1;
                        t     <= '0;
                        acc   <= bias_ext(b_q[dataWidth*nb_idx +: dataWidth]);
                        state <= MAC;
                    end
                end
                DONE: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lstm_gate_seq.sv
// Bench for lstm_gate_seq: a sigmoid and a tanh instance share stimulus and are
// compared against a sum-of-products reference model.
module tb_lstm_gate_seq;
    localparam int DW = 8;
    localparam int FW = 4;
    localparam int IS = 2;
    localparam int HS = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    lstm_gate_if #(.dataWidth(DW), .inputSize(IS), .hiddenSize(HS)) sif ();
    lstm_gate_if #(.dataWidth(DW), .inputSize(IS), .hiddenSize(HS)) tif ();

    lstm_gate_seq #(.dataWidth(DW), .fracWidth(FW), .inputSize(IS), .hiddenSize(HS),
                    .actType("sigmoid")) u_sig (.clk(clk), .rst(rst), .bus(sif));
    lstm_gate_seq #(.dataWidth(DW), .fracWidth(FW), .inputSize(IS), .hiddenSize(HS),
                    .actType("tanh")) u_tanh (.clk(clk), .rst(rst), .bus(tif));

    int total = 0;
    int bad   = 0;
    int xv[IS];
    int hv[HS];
    int wi[HS][IS];
    int wr[HS][HS];
    int bv[HS];
    int exp_s[HS], exp_t[HS], old_s[HS], old_t[HS];
    bit clamp_s, clamp_t;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    function automatic int clampi(input int v, input int lo, input int hi, inout bit cl);
        if (v > hi) begin cl = 1'b1; return hi; end
        if (v < lo) begin cl = 1'b1; return lo; end
        return v;
    endfunction

    task automatic model();
        int s, a;
        clamp_s = 1'b0;
        clamp_t = 1'b0;
        for (int i = 0; i < HS; i++) begin
            s = bv[i] * (1 << FW);
            for (int j = 0; j < IS; j++) s += xv[j] * wi[i][j];
            for (int k = 0; k < HS; k++) s += hv[k] * wr[i][k];
            a = s >>> FW;
            exp_s[i] = clampi((a >>> 2) + (1 << (FW-1)), 0, 1 << FW, clamp_s);
            exp_t[i] = clampi(a, -(1 << FW), 1 << FW, clamp_t);
        end
    endtask

    task automatic set_all(input int xval, input int hval, input int wval, input int bval);
        for (int j = 0; j < IS; j++) xv[j] = xval;
        for (int i = 0; i < HS; i++) begin
            hv[i] = hval;
            bv[i] = bval;
            for (int j = 0; j < IS; j++) wi[i][j] = wval;
            for (int k = 0; k < HS; k++) wr[i][k] = wval;
        end
    endtask

    task automatic set_random(input int lo, input int hi);
        for (int j = 0; j < IS; j++) xv[j] = $urandom_range(hi - lo) + lo;
        for (int i = 0; i < HS; i++) begin
            hv[i] = $urandom_range(hi - lo) + lo;
            bv[i] = $urandom_range(hi - lo) + lo;
            for (int j = 0; j < IS; j++) wi[i][j] = $urandom_range(hi - lo) + lo;
            for (int k = 0; k < HS; k++) wr[i][k] = $urandom_range(hi - lo) + lo;
        end
    endtask

    task automatic load_if();
        for (int j = 0; j < IS; j++) begin
            sif.x[DW*j +: DW] = DW'(xv[j]);
            tif.x[DW*j +: DW] = DW'(xv[j]);
        end
        for (int i = 0; i < HS; i++) begin
            sif.hid[DW*i +: DW] = DW'(hv[i]);
            tif.hid[DW*i +: DW] = DW'(hv[i]);
            sif.b[DW*i +: DW]   = DW'(bv[i]);
            tif.b[DW*i +: DW]   = DW'(bv[i]);
            for (int j = 0; j < IS; j++) begin
                sif.InW[DW*(IS*i+j) +: DW] = DW'(wi[i][j]);
                tif.InW[DW*(IS*i+j) +: DW] = DW'(wi[i][j]);
            end
            for (int k = 0; k < HS; k++) begin
                sif.ReW[DW*(HS*i+k) +: DW] = DW'(wr[i][k]);
                tif.ReW[DW*(HS*i+k) +: DW] = DW'(wr[i][k]);
            end
        end
    endtask

    task automatic scramble_if();
        sif.x = IS*DW'($urandom); tif.x = sif.x;
        sif.hid = HS*DW'($urandom); tif.hid = sif.hid;
        sif.b = HS*DW'($urandom); tif.b = sif.b;
        sif.InW = IS*HS*DW'($urandom); tif.InW = sif.InW;
        sif.ReW = HS*HS*DW'($urandom); tif.ReW = sif.ReW;
    endtask

    task automatic set_start(input logic v);
        sif.start = v;
        tif.start = v;
    endtask

    task automatic check_y(input string tag, input int es[HS], input int et[HS]);
        for (int i = 0; i < HS; i++) begin
            check($sformatf("%s sig y[%0d]", tag, i), $signed(sif.y[DW*i +: DW]), es[i]);
            check($sformatf("%s tanh y[%0d]", tag, i), $signed(tif.y[DW*i +: DW]), et[i]);
        end
    endtask

    task automatic count_pulses(input string tag, input int cycles);
        int pulses = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (sif.out_valid === 1'b1 || tif.out_valid === 1'b1) pulses++;
        end
        check({tag, " stray out_valid"}, pulses, 0);
    endtask

    // mode 0: plain run; 1: start spam + input changes while busy and in DONE; 2: reset in 4th MAC cycle
    task automatic run_gate(input string tag, input int mode);
        int cyc;
        model();
        @(negedge clk);
        load_if();
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        check({tag, " busy after start"}, sif.busy, 1);
        cyc = 0;
        while (sif.out_valid !== 1'b1 && cyc < 40) begin
            if (cyc == 5) begin
                check({tag, " sig y0 after first ACT"}, $signed(sif.y[DW-1:0]), exp_s[0]);
                check({tag, " sig y1 still old"}, $signed(sif.y[2*DW-1:DW]), old_s[1]);
                check({tag, " tanh y1 still old"}, $signed(tif.y[2*DW-1:DW]), old_t[1]);
            end
            if (mode == 1) begin
                scramble_if();
                set_start(1'($urandom_range(1)));
            end
            if (mode == 2 && cyc == 3) begin
                rst = 1'b0;
                @(negedge clk);
                rst = 1'b1;
                check({tag, " busy after reset"}, sif.busy, 0);
                check({tag, " out_valid after reset"}, tif.out_valid, 0);
                for (int i = 0; i < HS; i++) begin
                    old_s[i] = 0;
                    old_t[i] = 0;
                end
                check_y({tag, " after reset"}, old_s, old_t);
                count_pulses({tag, " aborted"}, 12);
                return;
            end
            @(negedge clk);
            cyc++;
        end
        check({tag, " latency"}, cyc, HS*(IS+HS+1));
        check({tag, " tanh out_valid"}, tif.out_valid, 1);
        check({tag, " busy in DONE"}, sif.busy, 1);
        check_y(tag, exp_s, exp_t);
`ifdef LSTM_GATE_OVF_EN
        check({tag, " sig ovf"}, sif.ovf, 32'(clamp_s));
        check({tag, " tanh ovf"}, tif.ovf, 32'(clamp_t));
`endif
        if (mode == 1) set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        check({tag, " out_valid single pulse"}, sif.out_valid, 0);
        check({tag, " busy back low"}, tif.busy, 0);
        if (mode == 1) begin
            count_pulses(tag, 14);
            check_y({tag, " held"}, exp_s, exp_t);
        end
        old_s = exp_s;
        old_t = exp_t;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        set_start(1'b0);
        set_all(0, 0, 0, 0);
        load_if();
        for (int i = 0; i < HS; i++) begin
            old_s[i] = 0;
            old_t[i] = 0;
        end
        repeat (3) @(negedge clk);
        check("reset busy", sif.busy, 0);
        check("reset out_valid", sif.out_valid, 0);
        check_y("reset", old_s, old_t);
        rst = 1'b1;

        set_all(0, 0, 0, 0);
        run_gate("t1 zero", 0);

        set_all(16, 0, 0, 0);
        wi[0][0] = 16; wi[0][1] = 16; wi[1][0] = 16; wi[1][1] = 16;
        bv[1] = -16;
        hv[0] = 0; hv[1] = 0;
        run_gate("t2 clamp", 0);

        set_all(0, 0, 0, 0);
        xv[0] = 16;
        wi[0][0] = 8;
        run_gate("t3 half", 0);

        set_all(127, 127, 127, 127);
        run_gate("t4 maxpos", 0);

        set_all(127, 127, -128, 0);
        run_gate("t4 maxneg", 0);

        for (int r = 0; r < 6; r++) begin
            if (r < 3) set_random(-24, 24);
            else       set_random(-128, 127);
            run_gate($sformatf("rand%0d", r), 0);
        end

        set_random(-40, 40);
        run_gate("t5 spam", 1);

        set_all(20, 20, 20, 20);
        run_gate("t6 abort", 2);
        set_all(0, 0, 0, 0);
        run_gate("t6 restart", 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
